// File: rtl/icebreaker_alu_uart.sv
// icebreaker_alu_uart: UART-attached integer ALU (echo / add32 / mul32) for the iCEBreaker board.
// All logic runs on the PLL core clock with a synchronous, active-high internal reset.

module icebreaker_pll (
  input  logic clk_ref,
  output logic clk_core
);
  // Behavioural stand-in; on the board this is SB_PLL40_PAD configured 12 -> 32.256 MHz.
  assign clk_core = clk_ref;
endmodule

module icebreaker_alu_uart #(
  parameter int CLKS_PER_BIT  = 280,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic CLK,
  input  logic BTN_N,
  input  logic RX,
  output logic TX
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;

  logic PLLOUTCORE;
  icebreaker_pll pll (.clk_ref(CLK), .clk_core(PLLOUTCORE));

  logic [1:0] rst_sync;
  logic       rst;
  always_ff @(posedge PLLOUTCORE) rst_sync <= {rst_sync[0], ~BTN_N};
  assign rst = rst_sync[1];

  logic [1:0] rx_sync;
  logic       rx_s, rx_prev;
  always_ff @(posedge PLLOUTCORE) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], RX};
      rx_prev <= rx_sync[1];
    end
  end
  assign rx_s = rx_sync[1];

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_bit, rx_bit_nx;
  logic [7:0]    rx_sh, rx_sh_nx;
  logic          rx_valid, rx_valid_nx;
  logic [7:0]    rx_byte;

  always_ff @(posedge PLLOUTCORE) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_sh    <= rx_sh_nx;
      rx_valid <= rx_valid_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_sh_nx    = rx_sh;
    rx_valid_nx = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_nx = RX_START;
          rx_cnt_nx   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) rx_cnt_nx = rx_cnt - 1'b1;
        else if (rx_s) rx_state_nx = RX_IDLE;
        else begin
          rx_state_nx = RX_DATA;
          rx_cnt_nx   = BIT_LAST;
          rx_bit_nx   = '0;
        end
      end
      RX_DATA: begin
        if (rx_cnt != '0) rx_cnt_nx = rx_cnt - 1'b1;
        else begin
          rx_sh_nx  = {rx_s, rx_sh[7:1]};
          rx_cnt_nx = BIT_LAST;
          rx_bit_nx = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) rx_cnt_nx = rx_cnt - 1'b1;
        else begin
          rx_valid_nx = rx_s;   // low stop bit: framing error, byte dropped
          rx_state_nx = RX_IDLE;
        end
      end
    endcase
  end
  assign rx_byte = rx_sh;

  // ---------------- TX byte FIFO ----------------
  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push, pop;
  logic [7:0]  push_data;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge PLLOUTCORE) begin
    if (push && !fifo_full) fifo_mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge PLLOUTCORE) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !fifo_full) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- UART transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t     tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_bit, tx_bit_nx;
  logic [7:0]    tx_sh, tx_sh_nx;
  logic          tx_line, tx_line_nx;

  always_ff @(posedge PLLOUTCORE) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_sh    <= tx_sh_nx;
      tx_line  <= tx_line_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_sh_nx    = tx_sh;
    pop         = 1'b0;
    unique case (tx_state)
      TX_IDLE: ;
      TX_START: begin
        if (tx_cnt != '0) tx_cnt_nx = tx_cnt - 1'b1;
        else begin
          tx_state_nx = TX_DATA;
          tx_cnt_nx   = BIT_LAST;
          tx_bit_nx   = '0;
        end
      end
      TX_DATA: begin
        if (tx_cnt != '0) tx_cnt_nx = tx_cnt - 1'b1;
        else begin
          tx_cnt_nx = BIT_LAST;
          tx_bit_nx = tx_bit + 1'b1;
          tx_sh_nx  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt != '0) tx_cnt_nx = tx_cnt - 1'b1;
        else tx_state_nx = TX_IDLE;
      end
    endcase
    // Last stop-bit cycle counts as idle so queued bytes go out with no gap.
    if ((tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == '0)) && !fifo_empty) begin
      pop         = 1'b1;
      tx_state_nx = TX_START;
      tx_cnt_nx   = BIT_LAST;
      tx_sh_nx    = fifo_mem[rd_ptr[AW-1:0]];
    end
    tx_line_nx = 1'b1;
    if (tx_state_nx == TX_START) tx_line_nx = 1'b0;
    else if (tx_state_nx == TX_DATA) tx_line_nx = tx_sh_nx[0];
  end
  assign TX = tx_line;

  // ---------------- Packet parser + ALU ----------------
  // state     | meaning
  // P_OPCODE  | waiting for opcode byte
  // P_RSVD    | waiting for reserved byte
  // P_LEN_LO  | waiting for length low byte
  // P_LEN_HI  | waiting for length high byte
  // P_PAYLOAD | consuming payload, echoing or accumulating operands
  // P_RESULT  | pushing the 4 result bytes (add/mul only)
  typedef enum logic [2:0] {P_OPCODE, P_RSVD, P_LEN_LO, P_LEN_HI, P_PAYLOAD, P_RESULT} p_state_t;
  p_state_t    p_state, p_state_nx;
  logic [7:0]  opcode, len_lo;
  logic [15:0] len_rx, pay_len, pay_cnt;
  logic [1:0]  op_idx, res_idx;
  logic [31:0] operand, operand_full, acc;
  logic        operand_done;
  logic        mul_busy;
  logic [5:0]  mul_cnt;
  logic [31:0] mul_a, mul_b, mul_p, mul_p_nx;

  assign len_rx       = {rx_byte, len_lo};
  assign operand_full = {rx_byte, operand[31:8]};
  assign mul_p_nx     = mul_p + (mul_b[0] ? mul_a : 32'd0);

  always_ff @(posedge PLLOUTCORE) begin
    if (rst) p_state <= P_OPCODE;
    else     p_state <= p_state_nx;
  end

  always_comb begin
    p_state_nx   = p_state;
    push         = 1'b0;
    push_data    = rx_byte;
    operand_done = 1'b0;
    unique case (p_state)
      P_OPCODE: if (rx_valid) p_state_nx = P_RSVD;
      P_RSVD:   if (rx_valid) p_state_nx = P_LEN_LO;
      P_LEN_LO: if (rx_valid) p_state_nx = P_LEN_HI;
      P_LEN_HI: if (rx_valid) p_state_nx = (len_rx <= 16'd4) ? P_RESULT : P_PAYLOAD;
      P_PAYLOAD: begin
        if (rx_valid) begin
          push         = (opcode == OP_ECHO);
          operand_done = (op_idx == 2'd3);
          if (pay_cnt + 16'd1 == pay_len) p_state_nx = P_RESULT;
        end
      end
      P_RESULT: begin
        if (opcode != OP_ADD && opcode != OP_MUL) p_state_nx = P_OPCODE;
        else if (!mul_busy) begin
          push      = 1'b1;
          push_data = acc[{res_idx, 3'b000} +: 8];
          if (res_idx == 2'd3) p_state_nx = P_OPCODE;
        end
      end
      default: p_state_nx = P_OPCODE;
    endcase
  end

  always_ff @(posedge PLLOUTCORE) begin
    if (rst) begin
      opcode   <= '0;
      len_lo   <= '0;
      pay_len  <= '0;
      pay_cnt  <= '0;
      op_idx   <= '0;
      res_idx  <= '0;
      operand  <= '0;
      acc      <= '0;
      mul_busy <= 1'b0;
      mul_cnt  <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_p    <= '0;
    end else begin
      if (p_state == P_OPCODE && rx_valid) begin
        opcode  <= rx_byte;
        acc     <= (rx_byte == OP_MUL) ? 32'd1 : 32'd0;
        op_idx  <= '0;
        pay_cnt <= '0;
        res_idx <= '0;
      end
      if (p_state == P_LEN_LO && rx_valid) len_lo <= rx_byte;
      if (p_state == P_LEN_HI && rx_valid) pay_len <= (len_rx <= 16'd4) ? 16'd0 : len_rx - 16'd4;
      if (p_state == P_PAYLOAD && rx_valid) begin
        pay_cnt <= pay_cnt + 16'd1;
        op_idx  <= op_idx + 2'd1;
        operand <= operand_full;
      end
      if (operand_done) begin
        if (opcode == OP_ADD) acc <= acc + operand_full;
        else if (opcode == OP_MUL) begin
          mul_busy <= 1'b1;
          mul_cnt  <= 6'd32;
          mul_a    <= acc;
          mul_b    <= operand_full;
          mul_p    <= '0;
        end
      end
      // Shift-add multiply: 32 cycles, far below the byte spacing on the line.
      if (mul_busy) begin
        mul_p   <= mul_p_nx;
        mul_a   <= {mul_a[30:0], 1'b0};
        mul_b   <= {1'b0, mul_b[31:1]};
        mul_cnt <= mul_cnt - 6'd1;
        if (mul_cnt == 6'd1) begin
          mul_busy <= 1'b0;
          acc      <= mul_p_nx;
        end
      end
      if (p_state == P_RESULT && push) res_idx <= res_idx + 2'd1;
    end
  end
endmodule

// File: tb/tb_icebreaker_alu_uart.sv
// Bench for icebreaker_alu_uart: UART host driver, frame monitor and a packet-level model of the ALU.
module tb_icebreaker_alu_uart;
  localparam int CPB       = 32;
  localparam int LAT_LIMIT = 68;

  logic CLK = 1'b0;
  logic BTN_N, RX, TX;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int mon_starts = 0;
  int last_stop_cyc = 0;
  bit mon_en = 1'b0, mon_busy = 1'b0, drop_frame = 1'b0, lat_armed = 1'b0;

  icebreaker_alu_uart #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(16)) dut (
    .CLK(CLK), .BTN_N(BTN_N), .RX(RX), .TX(TX)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame monitor: samples every bit just after it starts and just before it ends.
  initial begin : monitor
    logic [9:0] early, late;
    logic [7:0] got;
    int lat;
    forever begin
      @(negedge CLK);
      if (mon_en && TX === 1'b0) begin
        mon_busy = 1'b1;
        mon_starts++;
        if (lat_armed) begin
          lat_armed = 1'b0;
          lat = cyc - last_stop_cyc;
          checks++;
          if (lat > LAT_LIMIT) begin
            errors++;
            $display("FAIL result_latency: %0d cycles, limit %0d", lat, LAT_LIMIT);
          end
        end
        for (int k = 0; k < 10; k++) begin
          if (k > 0) @(negedge CLK);
          early[k] = TX;
          repeat (CPB - 1) @(negedge CLK);
          late[k] = TX;
        end
        got = early[8:1];
        if (drop_frame) drop_frame = 1'b0;
        else begin
          checks++;
          if (early !== late || early[0] !== 1'b0 || early[9] !== 1'b1) begin
            errors++;
            $display("FAIL tx_frame_shape: early=%b late=%b, need equal with start 0 stop 1", early, late);
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_byte: got %02h, none expected", got);
          end else check("tx_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic uart_send(input logic [7:0] b, input bit arm);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      RX = fr[k];
      if (k == 9) begin
        repeat (CPB / 2) @(negedge CLK);
        last_stop_cyc = cyc;
        if (arm) lat_armed = 1'b1;
        repeat (CPB - CPB / 2) @(negedge CLK);
      end else repeat (CPB) @(negedge CLK);
    end
  endtask

  function automatic int payload_len(input logic [7:0] p[$]);
    int len;
    len = int'({p[3], p[2]});
    return (len < 4) ? 0 : len - 4;
  endfunction

  // Packet-level reference: what the host must get back for one command packet.
  function automatic void model(input logic [7:0] p[$], output logic [7:0] r[$]);
    int npay;
    logic [31:0] acc, opnd;
    r.delete();
    npay = payload_len(p);
    if (p[0] == 8'hEC) begin
      for (int i = 0; i < npay; i++) r.push_back(p[4+i]);
    end else if (p[0] == 8'hA0 || p[0] == 8'hA1) begin
      acc = (p[0] == 8'hA1) ? 32'd1 : 32'd0;
      for (int k = 0; k + 4 <= npay; k += 4) begin
        opnd = {p[7+k], p[6+k], p[5+k], p[4+k]};
        acc = (p[0] == 8'hA0) ? acc + opnd : acc * opnd;
      end
      for (int i = 0; i < 4; i++) r.push_back(acc[8*i +: 8]);
    end
  endfunction

  task automatic run_pkt(input string name, input logic [7:0] p[$], input logic [7:0] e[$]);
    int budget, t;
    bit arm;
    arm = (p[0] == 8'hA0 || p[0] == 8'hA1) && payload_len(p) > 0;
    foreach (e[i]) exp_q.push_back(e[i]);
    for (int i = 0; i < p.size(); i++) uart_send(p[i], arm && (i == p.size() - 1));
    budget = (e.size() + 2) * 10 * CPB + 200;
    t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check({name, "_response_done"}, (t < budget) ? 32'd1 : 32'd0, 32'd1);
    repeat (2 * CPB) @(negedge CLK);
    check({name, "_nothing_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic idle_check(input string name, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge CLK);
      if (TX !== 1'b1) lows++;
    end
    check(name, lows, 32'd0);
  endtask

  initial begin : main
    logic [7:0] p[$];
    logic [7:0] e[$];
    int base, t, sel, npay, lenf;

    BTN_N = 1'b0;
    RX    = 1'b1;
    repeat (5) @(negedge CLK);
    check("tx_reset_state", {31'd0, TX}, 32'd1);
    BTN_N = 1'b1;
    idle_check("tx_idle_after_reset", 10000);
    mon_en = 1'b1;

    p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h5A};
    e = '{8'h41, 8'h5A};
    run_pkt("echo", p, e);

    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    e = '{8'h03, 8'h00, 8'h00, 8'h00};
    run_pkt("add", p, e);

    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    e = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_pkt("add_wrap", p, e);

    p = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    e = '{8'h0F, 8'h00, 8'h00, 8'h00};
    run_pkt("mul", p, e);

    base = mon_starts;
    p = '{8'h55, 8'h00, 8'h05, 8'h00, 8'hAA};
    e.delete();
    run_pkt("unknown_op", p, e);
    check("unknown_op_no_tx", mon_starts - base, 32'd0);

    p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
    e = '{8'h33};
    run_pkt("echo_after_unknown", p, e);

    p = '{8'hA0, 8'h00, 8'h04, 8'h00};
    e = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_pkt("add_empty", p, e);

    p = '{8'hA1, 8'h00, 8'h02, 8'h00};
    e = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_pkt("mul_len_below_4", p, e);

    p = '{8'hA0, 8'h00, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h09};
    e = '{8'h05, 8'h00, 8'h00, 8'h00};
    run_pkt("add_trailing", p, e);

    // Reset pulse while the second echo byte is on the line.
    p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    base = mon_starts;
    for (int i = 0; i < p.size(); i++) uart_send(p[i], 1'b0);
    t = 0;
    while (mon_starts < base + 2 && t < 40 * CPB) begin
      @(negedge CLK);
      t++;
    end
    check("second_echo_started", mon_starts - base, 32'd2);
    repeat (3 * CPB) @(negedge CLK);
    drop_frame = 1'b1;
    BTN_N = 1'b0;
    repeat (4) @(negedge CLK);
    check("tx_high_in_reset", {31'd0, TX}, 32'd1);
    @(negedge CLK);
    BTN_N = 1'b1;
    exp_q.delete();
    idle_check("tx_idle_after_abort", 20 * CPB);

    p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    e = '{8'h7E};
    run_pkt("echo_after_reset", p, e);

    for (int n = 0; n < 8; n++) begin
      sel = int'($urandom_range(0, 3));
      p.delete();
      case (sel)
        0:       p.push_back(8'hEC);
        1:       p.push_back(8'hA0);
        2:       p.push_back(8'hA1);
        default: p.push_back(8'h10 + 8'($urandom_range(0, 15)));
      endcase
      npay = int'($urandom_range(0, 11));
      lenf = npay + 4;
      if ($urandom_range(0, 7) == 0) begin
        npay = 0;
        lenf = int'($urandom_range(0, 3));
      end
      p.push_back(8'($urandom));
      p.push_back(lenf[7:0]);
      p.push_back(lenf[15:8]);
      for (int i = 0; i < npay; i++) p.push_back(8'($urandom));
      model(p, e);
      run_pkt("random", p, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icebreaker_alu_uart.md
Name: icebreaker_alu_uart

Overview:
- Top level for the iCEBreaker board: a UART-attached integer ALU.
- A host sends framed command packets over RX at 115200 baud 8N1; the block parses them, computes echo/add/multiply, and returns the result bytes on TX.
- Contains the PLL (12 MHz in → 32.256 MHz core clock), UART RX/TX, packet parser, ALU datapath and a TX byte FIFO.

Parameters:
- CLKS_PER_BIT, 280, core clocks per UART bit (32.256 MHz / 115200).
- TX_FIFO_DEPTH, 16, response byte FIFO entries (power of two).

Ports:
- CLK  input  1  board clock; drives a PLL instance named pll whose output net PLLOUTCORE is the single core clock for all logic.
- BTN_N  input  1  reset button, low when pressed.
- RX  input  1  UART receive line, idle high.
- TX  output  1  UART transmit line, idle high.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
  - Internal rst = NOT BTN_N, passed through a 2-flop synchronizer on PLLOUTCORE.
  - RX is also 2-flop synchronized.
- Reset state:
  - TX = 1; parser in IDLE; FIFO empty; accumulators 0.
  - Reset asserted mid-packet or mid-transmit aborts everything; TX = 1 on the next clock edge.
- UART RX:
  - A falling edge in idle starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2; if RX is high there, return to idle (glitch).
  - Data bits are sampled every CLKS_PER_BIT thereafter, LSB first.
  - Stop bit is sampled; if it is 0 the byte is discarded (framing error).
  - Emits a 1-cycle valid with the byte.
- UART TX:
  - 1 start bit, 8 data bits LSB first, 1 stop bit; each bit exactly CLKS_PER_BIT cycles.
  - Pops the FIFO whenever the FIFO is non-empty and TX is idle.
  - Back-to-back bytes have no idle gap.
- Packet format, bytes in order:
  - opcode;
  - reserved (ignored);
  - len_lo, len_hi: 16-bit little-endian total packet length including the 4 header bytes;
  - then len-4 payload bytes.
  - len < 4 is treated as 4 (no payload).
- Parser states: OPCODE → RSVD → LEN_LO → LEN_HI → PAYLOAD → RESULT → OPCODE.
  - Leaves PAYLOAD when the payload count reaches len-4.
  - With zero payload, goes directly from LEN_HI to RESULT.
- Opcodes:
  - 0xEC echo: each payload byte is pushed to the TX FIFO as it arrives. No extra result bytes.
  - 0xA0 add32:
    - Payload is consecutive 32-bit little-endian operands.
    - Result = sum modulo 2^32.
    - Zero operands → 0.
  - 0xA1 mul32:
    - Result = product modulo 2^32 (low 32 bits).
    - Zero operands → 1.
    - The multiply may be iterative but must finish ≤ 34 cycles per operand.
    - The parser must accept the next payload byte regardless, since bytes arrive ≥ 2800 cycles apart.
  - Any other opcode: payload consumed and discarded; no response.
- Operand and result rules:
  - Trailing payload bytes that do not form a complete 4-byte operand are ignored.
  - add32/mul32 push the 4 result bytes little-endian into the FIFO in RESULT.
  - First result start bit appears ≤ 64 cycles after the last payload stop-bit sample.
- FIFO:
  - Push when full drops the byte.
  - Simultaneous push and pop is allowed.
  - The host must not send a new packet until the previous response has completed.

Test Plan:
- Reset: BTN_N=0 for 5 cycles then 1 → TX holds 1 continuously; no start bit for 10 000 cycles.
- Echo: send EC 00 06 00 41 5A → TX returns 41 then 5A, each bit 280 cycles, stop bit 1.
- Add:
  - Send A0 00 0C 00 01 00 00 00 02 00 00 00 → TX returns 03 00 00 00.
  - Send A0 00 0C 00 FF FF FF FF 02 00 00 00 → 01 00 00 00 (wrap).
- Multiply: send A1 00 0C 00 03 00 00 00 05 00 00 00 → TX returns 0F 00 00 00.
- Edge cases:
  - Unknown opcode 55 00 05 00 AA → no TX activity.
  - A following echo EC 00 05 00 33 → TX returns 33.
  - A0 00 04 00 → TX returns 00 00 00 00.
- Reset mid-operation: pulse BTN_N low during the 2nd echo response byte → TX goes 1 and stays idle; a subsequent echo of 7E returns 7E.
